// File: rtl/ahb_bus_arbiter.sv
// Two-master arbiter in front of the AHB-lite bridge: data master wins,
// instruction master is guaranteed a slot after STARVE_LIMIT data grants.
module ahb_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_din,
    input  logic        m0_wr,
    input  logic [3:0]  m0_ben,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_dout,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_din,
    input  logic        m1_wr,
    input  logic [3:0]  m1_ben,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_dout,
    output logic        s_req,
    output logic [31:0] s_addr,
    output logic [31:0] s_din,
    output logic        s_wr,
    output logic [3:0]  s_ben,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_dout,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_grant;
    logic [3:0]  r_starve;
    logic [7:0]  r_to;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic        r_wr;
    logic [3:0]  r_ben;

    logic        w_do_grant;
    logic        w_grant_new;
    logic        w_addr_ok;
    logic        w_data_ok;
    logic [31:0] w_dout;
    logic        w_err;
    logic        w_to_hit;
    logic        w_starved;

    assign w_to_hit  = (r_to == 8'(TIMEOUT - 1));
    assign w_starved = (r_starve == 4'(STARVE_LIMIT));

    always_comb begin
        w_next      = r_state;
        w_do_grant  = 1'b0;
        w_grant_new = 1'b0;
        w_addr_ok   = 1'b0;
        w_data_ok   = 1'b0;
        w_dout      = '0;
        w_err       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    w_do_grant  = 1'b1;
                    w_grant_new = m1_req && (!m0_req || w_starved);
                    w_next      = ADDR;
                end
            end
            ADDR: begin
                // s_data_ok is deliberately ignored during the address phase
                if (s_addr_ok) begin
                    w_addr_ok = 1'b1;
                    w_next    = DATA;
                end else if (w_to_hit) begin
                    w_addr_ok = 1'b1;
                    w_data_ok = 1'b1;
                    w_err     = 1'b1;
                    w_next    = IDLE;
                end
            end
            DATA: begin
                if (s_data_ok) begin
                    w_data_ok = 1'b1;
                    w_dout    = r_wr ? 32'd0 : s_dout;
                    w_next    = IDLE;
                end else if (w_to_hit) begin
                    w_data_ok = 1'b1;
                    w_err     = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= 1'b0;
            r_starve <= '0;
            r_to     <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_wr     <= 1'b0;
            r_ben    <= '0;
        end else begin
            r_state <= w_next;
            if (w_do_grant) begin
                r_grant <= w_grant_new;
                r_to    <= '0;
                r_addr  <= w_grant_new ? m1_addr : m0_addr;
                r_din   <= w_grant_new ? m1_din  : m0_din;
                r_wr    <= w_grant_new ? m1_wr   : m0_wr;
                r_ben   <= w_grant_new ? m1_ben  : m0_ben;
                if (w_grant_new)
                    r_starve <= '0;
                else if (m1_req && !w_starved)
                    r_starve <= r_starve + 4'd1;
            end else if (r_state != IDLE) begin
                r_to <= r_to + 8'd1;
            end
        end
    end

    assign s_req      = (r_state == ADDR);
    assign s_addr     = r_addr;
    assign s_din      = r_din;
    assign s_wr       = r_wr;
    assign s_ben      = r_ben;
    assign bus_err    = w_err;

    assign m0_addr_ok = w_addr_ok & ~r_grant;
    assign m0_data_ok = w_data_ok & ~r_grant;
    assign m0_dout    = r_grant ? 32'd0 : w_dout;
    assign m1_addr_ok = w_addr_ok & r_grant;
    assign m1_data_ok = w_data_ok & r_grant;
    assign m1_dout    = r_grant ? w_dout : 32'd0;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: reads, writes, starvation,
// both timeout flavours and reset during a transfer.
module tb_ahb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_din, m1_din;
    logic        m0_wr, m1_wr;
    logic [3:0]  m0_ben, m1_ben;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_dout, m1_dout;
    logic        s_req, s_wr, s_addr_ok, s_data_ok, bus_err;
    logic [31:0] s_addr, s_din, s_dout;
    logic [3:0]  s_ben;

    int n_chk = 0;
    int n_pass = 0;
    logic [9:0] exp_seq;

    always #5 clk = ~clk;

    ahb_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_wr(m0_wr), .m0_ben(m0_ben),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_wr(m1_wr), .m1_ben(m1_ben),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_dout(m1_dout),
        .s_req(s_req), .s_addr(s_addr), .s_din(s_din), .s_wr(s_wr),
        .s_ben(s_ben), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .s_dout(s_dout), .bus_err(bus_err)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h want %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m0_req = 0; m1_req = 0;
        m0_addr = 0; m1_addr = 0; m0_din = 0; m1_din = 0;
        m0_wr = 0; m1_wr = 0; m0_ben = 0; m1_ben = 0;
        s_addr_ok = 0; s_data_ok = 0; s_dout = 0;
        step(); step();
        rst = 1'b0;
        #1;
        expect_eq("rst_sreq", s_req, 0);
        expect_eq("rst_saddr", s_addr, 0);
        expect_eq("rst_sben", s_ben, 0);
        expect_eq("rst_swr", s_wr, 0);
        expect_eq("rst_err", bus_err, 0);
        expect_eq("rst_oks", {m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok}, 0);
        expect_eq("rst_dout", m0_dout | m1_dout, 0);

        // single read, m0
        m0_req = 1; m0_addr = 32'h0000_1000; m0_wr = 0; m0_ben = 4'hF;
        #1 expect_eq("rd_idle_sreq", s_req, 0);
        step();
        #1;
        expect_eq("rd_sreq", s_req, 1);
        expect_eq("rd_saddr", s_addr, 32'h0000_1000);
        s_addr_ok = 1;
        #1;
        expect_eq("rd_aok0", m0_addr_ok, 1);
        expect_eq("rd_aok1", m1_addr_ok, 0);
        expect_eq("rd_dok_early", m0_data_ok, 0);
        step();
        s_addr_ok = 0; m0_req = 0;
        #1;
        expect_eq("rd_data_sreq", s_req, 0);
        expect_eq("rd_no_dok", m0_data_ok, 0);
        step();
        s_data_ok = 1; s_dout = 32'hDEAD_BEEF;
        #1;
        expect_eq("rd_dok0", m0_data_ok, 1);
        expect_eq("rd_dout0", m0_dout, 32'hDEAD_BEEF);
        expect_eq("rd_m1_quiet", {m1_addr_ok, m1_data_ok}, 0);
        expect_eq("rd_dout1", m1_dout, 0);
        expect_eq("rd_err", bus_err, 0);
        step();
        s_data_ok = 0;

        // write, m1; simultaneous strobes in ADDR
        m1_req = 1; m1_wr = 1; m1_ben = 4'b0011;
        m1_din = 32'h1234_5678; m1_addr = 32'h0000_2000;
        step();
        #1;
        expect_eq("wr_sreq", s_req, 1);
        expect_eq("wr_sdin", s_din, 32'h1234_5678);
        expect_eq("wr_sben", s_ben, 4'b0011);
        expect_eq("wr_swr", s_wr, 1);
        expect_eq("wr_saddr", s_addr, 32'h0000_2000);
        s_addr_ok = 1; s_data_ok = 1;
        #1;
        expect_eq("wr_aok1", m1_addr_ok, 1);
        expect_eq("wr_aok0", m0_addr_ok, 0);
        expect_eq("wr_both_no_dok", m1_data_ok, 0);
        step();
        s_addr_ok = 0; s_data_ok = 0; m1_req = 0;
        #1;
        expect_eq("wr_hold_sdin", s_din, 32'h1234_5678);
        expect_eq("wr_hold_sben", s_ben, 4'b0011);
        expect_eq("wr_hold_swr", s_wr, 1);
        expect_eq("wr_data_sreq", s_req, 0);
        s_data_ok = 1; s_dout = 32'hFFFF_FFFF;
        #1;
        expect_eq("wr_dok1", m1_data_ok, 1);
        expect_eq("wr_dout1", m1_dout, 0);
        expect_eq("wr_dok0", m0_data_ok, 0);
        step();
        s_data_ok = 0;

        // starvation: both held, minimum-time bridge
        m0_req = 1; m1_req = 1;
        m0_wr = 0; m1_wr = 0;
        m0_addr = 32'hA0; m1_addr = 32'hB1;
        exp_seq = 10'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            step();
            s_addr_ok = 1;
            #1;
            expect_eq($sformatf("starve_g%0d", i), m1_addr_ok, exp_seq[i]);
            expect_eq($sformatf("starve_a%0d", i), s_addr,
                      exp_seq[i] ? 32'hB1 : 32'hA0);
            step();
            s_addr_ok = 0; s_data_ok = 1;
            step();
            s_data_ok = 0;
        end
        m0_req = 0; m1_req = 0;

        // data-phase timeout, m0 read
        m0_req = 1; s_dout = 32'hAAAA_5555;
        step();
        for (int c = 1; c <= 8; c++) begin
            s_addr_ok = (c == 1);
            #1;
            if (c == 1) expect_eq("to_aok", m0_addr_ok, 1);
            expect_eq($sformatf("to_dok_c%0d", c), m0_data_ok, c == 8);
            expect_eq($sformatf("to_err_c%0d", c), bus_err, c == 8);
            if (c == 8) expect_eq("to_dout", m0_dout, 0);
            m0_req = 0;
            step();
        end
        s_addr_ok = 0;
        expect_eq("to_idle_sreq", s_req, 0);
        expect_eq("to_idle_err", bus_err, 0);

        // address-phase timeout, m1
        m1_req = 1; m1_addr = 32'hC0;
        step();
        for (int c = 1; c <= 8; c++) begin
            #1;
            expect_eq($sformatf("ato_sreq_c%0d", c), s_req, 1);
            expect_eq($sformatf("ato_all_c%0d", c),
                      {m1_addr_ok, m1_data_ok, bus_err}, (c == 8) ? 3'b111 : 3'b000);
            if (c == 8) m1_req = 0;
            step();
        end
        expect_eq("ato_idle_sreq", s_req, 0);

        // reset while waiting in DATA
        m1_req = 1; m1_addr = 32'hD0;
        step();
        s_addr_ok = 1;
        step();
        s_addr_ok = 0; m1_req = 0;
        step();
        rst = 1;
        #1 expect_eq("rstd_no_dok", m1_data_ok, 0);
        step();
        rst = 0;
        #1;
        expect_eq("rstd_sreq", s_req, 0);
        expect_eq("rstd_saddr", s_addr, 0);
        expect_eq("rstd_sdin", s_din, 0);
        expect_eq("rstd_sben", s_ben, 0);
        expect_eq("rstd_swr", s_wr, 0);
        s_data_ok = 1;
        #1 expect_eq("rstd_stray", {m0_data_ok, m1_data_ok, bus_err}, 0);
        step();
        s_data_ok = 0;
        m1_req = 1; m1_addr = 32'hE0; m1_wr = 1;
        m1_din = 32'h0BAD_F00D; m1_ben = 4'b1100;
        step();
        s_addr_ok = 1;
        #1;
        expect_eq("post_aok", m1_addr_ok, 1);
        expect_eq("post_saddr", s_addr, 32'hE0);
        step();
        s_addr_ok = 0; m1_req = 0; s_data_ok = 1;
        #1;
        expect_eq("post_dok", m1_data_ok, 1);
        expect_eq("post_dout", m1_dout, 0);
        expect_eq("post_err", bus_err, 0);
        step();
        s_data_ok = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Two-master arbiter that shares the single AHB-lite bridge port between the instruction-fetch bus interface (master 1) and the data-memory bus interface (master 0). It sits between the two CPU-side bus interface units and the AHB bridge. It grants one transaction at a time: data has priority, and a starvation limit guarantees instruction fetch progress. A response timeout turns a hung transfer into a completed one with an error pulse.

## Interface
Parameters:
- STARVE_LIMIT, 4 — consecutive data grants allowed while inst is waiting; legal range 1..15.
- TIMEOUT, 255 — maximum cycles spent in ADDR+DATA per transfer before forced completion; legal range 2..255.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1).
- m0_req / m1_req  in  1  master request; level held until its addr_ok.
- m0_addr / m1_addr  in  32  physical address.
- m0_din / m1_din  in  32  write data.
- m0_wr / m1_wr  in  1  1 = write.
- m0_ben / m1_ben  in  4  byte enables.
- m0_addr_ok / m1_addr_ok  out  1  one-cycle pulse: request accepted.
- m0_data_ok / m1_data_ok  out  1  one-cycle pulse: transfer complete.
- m0_dout / m1_dout  out  32  read data; valid only with the matching data_ok, 0 otherwise.
- s_req  out  1  request to the bridge.
- s_addr, s_din  out  32  latched request fields.
- s_wr  out  1  latched write flag.
- s_ben  out  4  latched byte enables.
- s_addr_ok  in  1  bridge accepted the address phase.
- s_data_ok  in  1  bridge completed the data phase.
- s_dout  in  32  bridge read data.
- bus_err  out  1  one-cycle pulse on timeout completion.

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: grant (1 b), starve_cnt (4 b), to_cnt (8 b), and latched addr/din/wr/ben.
- IDLE, arbitration:
  - m0_req only → grant 0.
  - m1_req only → grant 1.
  - Both requesting → grant 1 if starve_cnt == STARVE_LIMIT, else grant 0.
  - On any grant: latch the granted master's fields, clear to_cnt, go ADDR.
  - No request → stay IDLE.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when grant 0 is issued while m1_req = 1.
  - Clears when grant 1 is issued.
  - Otherwise holds.
- ADDR:
  - s_req = 1 and s_* carry the latched fields.
  - s_addr_ok = 1 → pulse m{grant}_addr_ok in the same cycle, go DATA.
- DATA:
  - s_req = 0; s_* fields are held.
  - s_data_ok = 1 → pulse m{grant}_data_ok in the same cycle, go IDLE.
  - m{grant}_dout = s_dout if latched wr = 0, else 0.
- Timeout:
  - to_cnt increments each cycle in ADDR or DATA.
  - If to_cnt == TIMEOUT-1 and the state's completion strobe is absent, force completion:
    - in ADDR, pulse m{grant}_addr_ok and m{grant}_data_ok together;
    - in DATA, pulse m{grant}_data_ok only;
    - in both cases dout = 0, bus_err = 1, next state IDLE.
- Simultaneous events:
  - s_addr_ok and s_data_ok together in ADDR → addr_ok only; s_data_ok is ignored in that cycle.
  - A strobe arriving in the timeout cycle wins; no bus_err.
- Only one of m0_*_ok / m1_*_ok is ever asserted in a cycle. The non-granted master's ok outputs and dout stay 0.
- Stray s_addr_ok / s_data_ok in IDLE are ignored.
- A master dropping req while not granted is legal. Dropping req after grant has no effect; the transfer completes.

## Timing
- Reset values: state IDLE; s_req, s_wr, all ok pulses and bus_err 0; s_addr, s_din, m*_dout 0; s_ben 0000; starve_cnt and to_cnt 0.
- Reset asserted mid-transfer → next edge returns to IDLE with no ok pulse. The in-flight bridge transfer is abandoned; the bridge is reset by the same rst.
- Minimum latency: req seen in IDLE at cycle N → s_req at N+1 → earliest addr_ok at N+1 → earliest data_ok at N+2 → next grant evaluated at N+3.
- addr_ok, data_ok and dout are combinational from the bridge strobes. Everything else is registered.
- Back-to-back throughput: 3 cycles per transfer minimum (IDLE, ADDR, DATA).

## Test plan
- Single read, m0: m0_addr = 0x0000_1000, wr = 0; bridge gives addr_ok at cycle 1 and data_ok with s_dout = 0xDEAD_BEEF at cycle 3 → m0_addr_ok at 1, m0_data_ok at 3 with m0_dout = 0xDEAD_BEEF, m1 outputs 0.
- Write, m1: m1_wr = 1, ben = 0011, din = 0x1234_5678 → s_din, s_ben and s_wr match through ADDR/DATA; m1_dout = 0 at data_ok.
- Starvation: m0_req and m1_req held high, bridge answers every transfer in minimum time → grant sequence 0,0,0,0,1,0,0,0,0,1.
- Timeout: TIMEOUT = 8; bridge gives addr_ok but never data_ok → data_ok and bus_err pulse together in the 8th cycle after the grant; dout = 0; arbiter is back in IDLE next cycle.
- Addr-phase timeout: TIMEOUT = 8; no s_addr_ok → addr_ok, data_ok and bus_err all pulse together in one cycle.
- Reset mid-DATA: rst for 1 cycle while waiting → all outputs at reset values, no data_ok; a subsequent m1 request completes normally.
